// File: rtl/circ_buf_multi.sv
// ---------------------------------------------------------------------------
// circ_buf_multi
//   Circular sample history with multi-lane group reads. Every write appends
//   one sample; a read returns LANES consecutive samples selected by a group
//   index counted back from the newest sample. The newest sample of the group
//   is in the most-significant lane. Lanes older than the number of samples
//   held since reset read as zero.
//
//   Storage is split into LANES banks, bank b holding every physical address
//   whose low log2(LANES) bits equal b. A group of LANES consecutive addresses
//   therefore touches every bank exactly once. The banks are then rotated
//   back into lane order.
//
//   Read timing: request at edge n, bank read at edge n, lane data staged at
//   edge n+1, dout/rd_valid registered at edge n+2.
//
// Parameters
//   DW     sample width in bits
//   AW     log2 of buffer depth
//   LANES  samples per read (power of two, 1..16, LANES < 2^AW)
//
// Ports
//   clock     master clock, rising edge
//   reset     synchronous, active-high; clears pointer, fill, dout, rd_valid
//   din       sample to write
//   wen       write strobe
//   rd_req    read request, accepted every cycle
//   rd_addr   group index K relative to the newest sample
//   dout      LANES samples, lane j at bits [j*DW +: DW]
//   rd_valid  one-cycle pulse qualifying dout
//   fill      number of valid samples held, saturating at 2^AW
// ---------------------------------------------------------------------------
module circ_buf_multi #(
   parameter int DW    = 18,
   parameter int AW    = 14,
   parameter int LANES = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DW-1:0]                 din,
   input  logic                          wen,
   input  logic                          rd_req,
   input  logic [AW-$clog2(LANES)-1:0]   rd_addr,
   output logic [DW*LANES-1:0]           dout,
   output logic                          rd_valid,
   output logic [AW:0]                   fill
);

   localparam int LB   = $clog2(LANES);
   localparam int LBW  = (LB == 0) ? 1 : LB;
   localparam int RW   = AW - LB;
   localparam int NROW = 1 << RW;
   localparam logic [AW:0] FULL = (AW+1)'(1) << AW;

   // Ages covered by lane j of group k are k*LANES + (LANES-1-j); a lane is
   // visible only when its age is below the fill level seen by the request.
   function automatic logic [LANES-1:0] age_mask(input logic [RW-1:0] k,
                                                 input logic [AW:0]   fill_s);
      logic [LANES-1:0] m;
      logic [AW:0]      age;
      m = '0;
      for (int j = 0; j < LANES; j++) begin
         age  = ((AW+1)'(k) << LB) + (AW+1)'(LANES - 1 - j);
         m[j] = (age < fill_s);
      end
      return m;
   endfunction

   // Lane j sits at physical address start+j, which lives in bank
   // (start_lo + j) mod LANES.
   function automatic logic [DW*LANES-1:0] align_lanes(
      input logic [DW*LANES-1:0] banks,
      input logic [LBW-1:0]      slo,
      input logic [LANES-1:0]    mask);
      logic [DW*LANES-1:0] res;
      logic [LBW-1:0]      idx;
      res = '0;
      for (int j = 0; j < LANES; j++) begin
         idx = (slo + LBW'(j)) & LBW'(LANES - 1);
         if (mask[j]) res[j*DW +: DW] = banks[idx*DW +: DW];
      end
      return res;
   endfunction

   logic [AW-1:0]       r_wptr;
   logic [AW:0]         r_fill;

   logic [AW-1:0]       w_kofs;
   logic [AW-1:0]       w_start;
   logic [LBW-1:0]      w_slo;
   logic [RW-1:0]       w_srow;
   logic [LBW-1:0]      w_wbank;
   logic [RW-1:0]       w_wrow;
   logic [DW*LANES-1:0] w_bank_q;

   logic                r_vld_p0;
   logic [RW-1:0]       r_k_p0;
   logic [AW:0]         r_fill_p0;
   logic [LBW-1:0]      r_slo_p0;

   logic                r_vld_p1;
   logic [DW*LANES-1:0] r_bank_p1;
   logic [LBW-1:0]      r_slo_p1;
   logic [LANES-1:0]    r_mask_p1;

   assign fill = r_fill;

   // Write pointer and fill level; writes during reset are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr <= '0;
         r_fill <= '0;
      end else if (wen) begin
         r_wptr <= r_wptr + 1'b1;
         if (r_fill != FULL) r_fill <= r_fill + 1'b1;
      end
   end

   // Group k starts (oldest lane) at wptr - (k+1)*LANES; the subtraction wraps
   // naturally in AW bits, which handles groups straddling address 0.
   assign w_kofs  = AW'(rd_addr) << LB;
   assign w_start = r_wptr - w_kofs - AW'(LANES);

   generate
      if (LB > 0) begin : g_split
         assign w_slo   = w_start[LB-1:0];
         assign w_srow  = w_start[AW-1:LB];
         assign w_wbank = r_wptr[LB-1:0];
         assign w_wrow  = r_wptr[AW-1:LB];
      end else begin : g_nosplit
         assign w_slo   = '0;
         assign w_srow  = w_start;
         assign w_wbank = '0;
         assign w_wrow  = r_wptr;
      end
   endgenerate

   // ---- stage p0: bank reads issued with the request ----
   // Each bank reads read-first, so a write landing in the same edge is not
   // seen by the read; this keeps a simultaneous write out of the group even
   // when the buffer is full and the group reaches the slot being overwritten.
   generate
      for (genvar b = 0; b < LANES; b++) begin : g_bank
         logic [DW-1:0] r_mem [NROW];
         logic [DW-1:0] r_q_p0;
         logic [RW-1:0] w_rrow;

         // Banks below the start offset hold lanes that wrapped into the next row.
         assign w_rrow = (LBW'(b) < w_slo) ? (w_srow + 1'b1) : w_srow;

         always_ff @(posedge clock) begin
            if (wen && !reset && (w_wbank == LBW'(b))) r_mem[w_wrow] <= din;
            if (rd_req) r_q_p0 <= r_mem[w_rrow];
         end

         assign w_bank_q[b*DW +: DW] = r_q_p0;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) r_vld_p0 <= 1'b0;
      else       r_vld_p0 <= rd_req;
      if (rd_req) begin
         r_k_p0    <= rd_addr;
         r_fill_p0 <= r_fill;
         r_slo_p0  <= w_slo;
      end
   end

   // ---- stage p1: bank data staged, lane mask resolved ----
   always_ff @(posedge clock) begin
      if (reset) r_vld_p1 <= 1'b0;
      else       r_vld_p1 <= r_vld_p0;
      r_bank_p1 <= w_bank_q;
      r_slo_p1  <= r_slo_p0;
      r_mask_p1 <= age_mask(r_k_p0, r_fill_p0);
   end

   // ---- stage p2: rotated, masked output register ----
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid <= 1'b0;
         dout     <= '0;
      end else begin
         rd_valid <= r_vld_p1;
         if (r_vld_p1) dout <= align_lanes(r_bank_p1, r_slo_p1, r_mask_p1);
      end
   end

endmodule

// File: tb/tb_circ_buf_multi.sv
module tb_circ_buf_multi;

   localparam int DW    = 18;
   localparam int AW    = 6;
   localparam int LANES = 4;
   localparam int KW    = AW - $clog2(LANES);
   localparam int OW    = DW * LANES;
   localparam int DEPTH = 1 << AW;
   localparam int MAXK  = (1 << KW) - 1;

   logic            clock;
   logic            reset;
   logic [DW-1:0]   din;
   logic            wen;
   logic            rd_req;
   logic [KW-1:0]   rd_addr;
   logic [OW-1:0]   dout;
   logic            rd_valid;
   logic [AW:0]     fill;

   int n_tests;
   int n_fail;

   circ_buf_multi #(.DW(DW), .AW(AW), .LANES(LANES)) dut (
      .clock    (clock),
      .reset    (reset),
      .din      (din),
      .wen      (wen),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .dout     (dout),
      .rd_valid (rd_valid),
      .fill     (fill)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_q holds the retained samples, oldest first; its size is the fill level.
   logic [DW-1:0] m_q[$];
   int            m_due[$];
   logic [OW-1:0] m_data[$];
   int            cyc_n;
   bit            m_live;
   bit            m_vld;
   logic [OW-1:0] m_dout;

   function automatic logic [OW-1:0] model_read(input int k);
      logic [OW-1:0] r;
      int age;
      r = '0;
      for (int j = 0; j < LANES; j++) begin
         age = k * LANES + (LANES - 1 - j);
         if (age < m_q.size()) r[j*DW +: DW] = m_q[m_q.size() - 1 - age];
      end
      return r;
   endfunction

   initial begin
      cyc_n  = 0;
      m_live = 0;
      m_vld  = 0;
      m_dout = '0;
   end

   always @(posedge clock) begin
      cyc_n++;
      m_live = 1;
      if (reset) begin
         m_q.delete();
         m_due.delete();
         m_data.delete();
         m_vld  = 0;
         m_dout = '0;
      end else begin
         // Read sees the buffer as it was before this edge's write.
         if (rd_req) begin
            m_due.push_back(cyc_n + 2);
            m_data.push_back(model_read(int'(rd_addr)));
         end
         if (wen) begin
            m_q.push_back(din);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
         end
         m_vld = 0;
         if (m_due.size() > 0 && m_due[0] == cyc_n) begin
            m_vld  = 1;
            m_dout = m_data[0];
            void'(m_due.pop_front());
            void'(m_data.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      if (m_live) begin
         chk("model rd_valid", OW'(rd_valid), OW'(m_vld));
         chk("model fill", OW'(fill), OW'(m_q.size()));
         chk("model dout", dout, m_dout);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input int k);
      wen     = w;
      din     = d;
      rd_req  = r;
      rd_addr = KW'(k);
      @(posedge clock);
      #1;
      wen    = 1'b0;
      rd_req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0, '0, 1'b0, 0);
      reset = 1'b0;
   endtask

   task automatic read_lit(input string name, input int k, input logic [OW-1:0] exp);
      cyc(1'b0, '0, 1'b1, k);
      cyc(1'b0, '0, 1'b0, 0);
      cyc(1'b0, '0, 1'b0, 0);
      chk({name, " rd_valid"}, OW'(rd_valid), OW'(1));
      chk(name, dout, exp);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      din     = '0;
      wen     = 1'b0;
      rd_req  = 1'b0;
      rd_addr = '0;
      cyc(1'b0, '0, 1'b0, 0);
      cyc(1'b0, '0, 1'b0, 0);
      reset = 1'b0;
      chk("reset rd_valid", OW'(rd_valid), OW'(0));
      chk("reset dout", dout, '0);
      chk("reset fill", OW'(fill), OW'(0));

      // Eight writes, two groups.
      for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0, 0);
      read_lit("w8 k0", 0, {18'd8, 18'd7, 18'd6, 18'd5});
      read_lit("w8 k1", 1, {18'd4, 18'd3, 18'd2, 18'd1});

      // Partial fill: unwritten lanes are masked.
      do_reset();
      cyc(1'b1, 18'd1, 1'b0, 0);
      cyc(1'b1, 18'd2, 1'b0, 0);
      read_lit("w2 k0", 0, {18'd2, 18'd1, 18'd0, 18'd0});
      read_lit("w2 k5", 5, '0);
      chk("w2 fill", OW'(fill), OW'(2));

      // Overfill by 3: saturation, wrap-straddling group, oldest group.
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) cyc(1'b1, DW'(i), 1'b0, 0);
      chk("sat fill", OW'(fill), OW'(DEPTH));
      read_lit("sat k0", 0, {18'd66, 18'd65, 18'd64, 18'd63});
      read_lit("sat kmax", MAXK, {18'd6, 18'd5, 18'd4, 18'd3});
      // Write lands on the slot of the oldest lane in the same cycle.
      cyc(1'b1, 18'd999, 1'b1, MAXK);
      cyc(1'b0, '0, 1'b0, 0);
      cyc(1'b0, '0, 1'b0, 0);
      chk("sat wr+kmax", dout, {18'd6, 18'd5, 18'd4, 18'd3});
      read_lit("sat kmax after", MAXK, {18'd7, 18'd6, 18'd5, 18'd4});
      read_lit("sat k0 after", 0, {18'd999, 18'd66, 18'd65, 18'd64});

      // Simultaneous write and read.
      do_reset();
      for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b0, 0);
      cyc(1'b1, 18'd9, 1'b1, 0);
      cyc(1'b0, '0, 1'b0, 0);
      cyc(1'b0, '0, 1'b0, 0);
      chk("rw same cycle valid", OW'(rd_valid), OW'(1));
      chk("rw same cycle", dout, {18'd4, 18'd3, 18'd2, 18'd1});

      // Back-to-back reads.
      do_reset();
      for (int i = 1; i <= 20; i++) cyc(1'b1, DW'(i), 1'b0, 0);
      for (int t = 0; t < 7; t++) begin
         cyc(1'b0, '0, (t < 5), t);
         if (t >= 2) begin
            chk("b2b valid", OW'(rd_valid), OW'(1));
            chk("b2b dout", dout, {DW'(20 - 4*(t-2)), DW'(19 - 4*(t-2)),
                                   DW'(18 - 4*(t-2)), DW'(17 - 4*(t-2))});
         end
      end
      cyc(1'b0, '0, 1'b0, 0);
      chk("b2b end", OW'(rd_valid), OW'(0));

      // Reset squashes a read in flight and ignores strobes in its cycle.
      do_reset();
      for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b0, 0);
      cyc(1'b0, '0, 1'b1, 0);
      reset = 1'b1;
      cyc(1'b1, 18'd77, 1'b1, 0);
      reset = 1'b0;
      chk("squash v1", OW'(rd_valid), OW'(0));
      cyc(1'b0, '0, 1'b0, 0);
      chk("squash v2", OW'(rd_valid), OW'(0));
      cyc(1'b0, '0, 1'b0, 0);
      chk("squash v3", OW'(rd_valid), OW'(0));
      chk("squash fill", OW'(fill), OW'(0));
      read_lit("squash k0", 0, '0);

      // Randomized traffic against the model.
      for (int t = 0; t < 3000; t++) begin
         reset = ($urandom_range(0, 199) == 0);
         cyc(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 1) == 1),
             int'($urandom_range(0, MAXK)));
         reset = 1'b0;
      end
      for (int t = 0; t < 4; t++) cyc(1'b0, '0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/circ_buf_multi.md
CIRC_BUF_MULTI -- requirements
Module: circ_buf_multi

Interface
REQ-001 The block SHALL provide parameter DW, default 18, meaning sample width in bits.
REQ-002 The block SHALL provide parameter AW, default 14, meaning log2 of buffer depth (depth = 2^AW samples).
REQ-003 The block SHALL provide parameter LANES, default 4, meaning samples returned per read (power of 2, 1..16, LANES < 2^AW).
REQ-004 The block SHALL have port clock, input, 1, master clock (rising edge).
REQ-005 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-006 The block SHALL have port din, input, DW, sample to write.
REQ-007 The block SHALL have port wen, input, 1, write strobe.
REQ-008 The block SHALL have port rd_req, input, 1, read request.
REQ-009 The block SHALL have port rd_addr, input, AW-log2(LANES), group index relative to newest sample.
REQ-010 The block SHALL have port dout, output, DW*LANES, read data.
REQ-011 The block SHALL have port rd_valid, output, 1, one-cycle pulse qualifying dout.
REQ-012 The block SHALL have port fill, output, AW+1, count of valid samples held.

Function
REQ-013 On a clock edge with wen=1, the block SHALL write din at the internal write pointer and increment it modulo 2^AW.
REQ-014 fill SHALL increment on each write and saturate at 2^AW.
REQ-015 Sample age SHALL be defined as 0 for the newest written sample, 1 for the one before, and so on.
REQ-016 A read with rd_addr=K SHALL return in lane j (dout bits [j*DW +: DW]) the sample of age K*LANES + (LANES-1-j): newest in the MS lane, oldest in lane 0.
REQ-017 Any lane whose age >= fill SHALL read as zero, masking stale or unwritten memory.
REQ-018 Write pointer and fill SHALL be sampled in the rd_req cycle before that cycle's write takes effect, so a simultaneous write is not visible to that read.
REQ-019 rd_valid SHALL pulse exactly 2 cycles after the rd_req edge (rd_req at edge n gives rd_valid high after edge n+2).
REQ-020 dout SHALL be registered and SHALL hold its value until the next rd_valid.
REQ-021 rd_req SHALL be accepted on every cycle (fully pipelined, throughput 1 read/cycle, no backpressure).
REQ-022 Read group addresses SHALL wrap modulo 2^AW; a group straddling pointer wrap (e.g. ages spanning physical address 0 and 2^AW-1) SHALL be returned correctly.
REQ-023 Storage SHALL be organised as LANES banks of 2^AW/LANES words, each with one synchronous write port and one synchronous read port, to allow block-RAM inference.
REQ-024 No lane SHALL be read from more than one bank per cycle.
REQ-025 Bank outputs SHALL be rotated by the low log2(LANES) bits of the read start address to align lanes.
REQ-026 Requests with K*LANES >= 2^AW cannot occur by width; a read at the maximum K SHALL return the oldest LANES samples.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL clear the write pointer, fill, and dout to 0 and rd_valid to 0.
REQ-028 Reset SHALL squash any read in flight, so no rd_valid pulse is produced for requests issued within the 2 cycles before or during reset.
REQ-029 wen and rd_req asserted in the reset cycle SHALL be ignored.
REQ-030 Memory contents SHALL NOT be cleared by reset; REQ-017 masking SHALL make old contents invisible.

Verification
REQ-031 The bench SHALL cover: write 1..8 (DW=18, LANES=4), rd_req K=0 -> after 2 cycles rd_valid=1, dout={8,7,6,5}; K=1 -> {4,3,2,1}.
REQ-032 The bench SHALL cover: after reset write 1,2 only, read K=0 -> {2,1,0,0}; read K=5 -> all zero; fill=2.
REQ-033 The bench SHALL cover: write 2^AW+3 samples valued by index -> fill saturates at 2^AW; K=0 returns the last 4 indices across pointer wrap; max K returns the oldest 4 retained.
REQ-034 The bench SHALL cover: write value 9 with wen and rd_req K=0 in the same cycle, after prior writes 1..4 -> dout={4,3,2,1}, not containing 9.
REQ-035 The bench SHALL cover: rd_req on 5 consecutive cycles with K=0..4 -> 5 consecutive rd_valid pulses with matching data in order.
REQ-036 The bench SHALL cover: rd_req, then reset one cycle later -> no rd_valid; fill=0; subsequent K=0 read -> all zero.
